vga_display: RTL and testbench



---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing.sv | 64 ++++++
 rtl/vga_display.sv | 86 ++++++++
 tb/tb_vga_display.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, derived totals and colour-bar table.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int CLK_DIV   = 4;

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    // RGB332 per bar, element 0 is the leftmost (white) bar.
    localparam logic [7:0][7:0] BAR_RGB = {
        8'h00, 8'h03, 8'hE0, 8'hE3, 8'h1C, 8'h1F, 8'hFC, 8'hFF
    };

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v counters and combinational sync/active decode.
// Latency: decode is combinational from the current counter values.
// Backpressure: none; free-running from reset release.
module vga_timing #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter int CLK_DIV   = vga_pkg::CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcount,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active
);
    import vga_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_ACT    = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT    = 10'(V_VISIBLE);

    logic [DIV_W-1:0] div;
    logic [9:0]       vcount;
    logic             pix_en;

    assign pix_en = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    assign hsync_n = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    assign vsync_n = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    assign active  = (hcount < H_ACT) && (vcount < V_ACT);

endmodule

// File: rtl/vga_display.sv
// VGA 640x480@60 colour-bar generator: timing, bar decode, registered pin drivers.
// Latency: all pins one system clock behind the counters, sync and colour aligned.
// Backpressure: none; free-running source straight to the connector.
module vga_display #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter int CLK_DIV   = vga_pkg::CLK_DIV
) (
    input  logic       CLK_100M,
    input  logic       RST_N,
    output logic       hsync_pin,
    output logic       vsync_pin,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [2:1] blue
);
    import vga_pkg::*;

    localparam int BAR_W = H_VISIBLE / 8;

    logic [9:0] hcount;
    logic       hsync_n;
    logic       vsync_n;
    logic       active;
    logic [2:0] bar;
    rgb_t       pix_rgb;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CLK_DIV   (CLK_DIV)
    ) u_timing (
        .clk     (CLK_100M),
        .rst_n   (RST_N),
        .hcount  (hcount),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n),
        .active  (active)
    );

    // Bar index from a comparator ladder on the bar boundaries.
    always_comb begin
        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hcount >= 10'(BAR_W * i)) begin
                bar = 3'(i);
            end
        end
    end

    always_comb begin
        pix_rgb = '0;
        if (active) begin
            pix_rgb = rgb_t'(BAR_RGB[bar]);
        end
    end

    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            hsync_pin <= 1'b1;
            vsync_pin <= 1'b1;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            hsync_pin <= hsync_n;
            vsync_pin <= vsync_n;
            red       <= pix_rgb.r;
            green     <= pix_rgb.g;
            blue      <= pix_rgb.b;
        end
    end

endmodule

// File: tb/tb_vga_display.sv
// Directed scoreboard bench for vga_display: full horizontal timing, shortened frame.
// Frame is cut to 6 lines (2 visible, 1 front, 2 sync, 1 back) to keep run time short.
module tb_vga_display;

    localparam int VV = 2;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int LINE  = 3200;
    localparam int FRAME = (VV + VF + VS + VB) * LINE;

    logic       clk;
    logic       rst_n;
    logic       hsync_pin;
    logic       vsync_pin;
    logic [2:0] red;
    logic [2:0] green;
    logic [2:1] blue;

    int compared   = 0;
    int mismatched = 0;
    int edge_cnt   = 0;

    int    exp_q[$];
    string tag_q[$];

    vga_display #(
        .V_VISIBLE (VV),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB)
    ) dut (
        .CLK_100M  (clk),
        .RST_N     (rst_n),
        .hsync_pin (hsync_pin),
        .vsync_pin (vsync_pin),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_rgb(input int x, input int y);
        if (x >= 640 || y >= VV) return 0;
        case (x / 80)
            0:       return 'hFF;
            1:       return 'hFC;
            2:       return 'h1F;
            3:       return 'h1C;
            4:       return 'hE3;
            5:       return 'hE0;
            6:       return 'h03;
            default: return 'h00;
        endcase
    endfunction

    function automatic int rgb_now();
        return int'({red, green, blue});
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        edge_cnt += n;
    endtask

    task automatic goto_edge(input int e);
        if (e > edge_cnt) step(e - edge_cnt);
    endtask

    task automatic sb_push(input string tag, input int exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_check(input int obs);
        int    e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
        end
    endtask

    // Walks edges until the selected sync pin reaches lvl; returns -1 on timeout.
    task automatic wait_pin(input bit sel_v, input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < 25000; i++) begin
            step(1);
            if ((sel_v ? vsync_pin : hsync_pin) === lvl) begin
                at = edge_cnt;
                break;
            end
        end
    endtask

    task automatic check_px(input string tag, input int base, input int x, input int y);
        sb_push(tag, exp_rgb(x, y));
        goto_edge(base + 4 * x + 2);
        sb_check(rgb_now());
    endtask

    int t_fall;
    int t_rise;
    int t_next;
    int v_fall;
    int v_rise;

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb_push("rst_hsync", 1); sb_check(int'(hsync_pin));
        sb_push("rst_vsync", 1); sb_check(int'(vsync_pin));
        sb_push("rst_rgb", 0);   sb_check(rgb_now());
        rst_n = 1'b1;
        edge_cnt = 0;

        // First line: pixel enable phase and bar colours.
        sb_push("pix_en_e2", 0);
        goto_edge(2);
        sb_check(int'(dut.u_timing.pix_en));
        check_px("x0_white", 0, 0, 0);
        sb_push("pix_en_e3", 1);
        goto_edge(3);
        sb_check(int'(dut.u_timing.pix_en));
        sb_push("pix_en_e4", 0);
        goto_edge(4);
        sb_check(int'(dut.u_timing.pix_en));
        check_px("x80_yellow", 0, 80, 0);
        check_px("x160_cyan", 0, 160, 0);
        check_px("x240_green", 0, 240, 0);
        check_px("x320_magenta", 0, 320, 0);
        check_px("x400_red", 0, 400, 0);
        check_px("x480_blue", 0, 480, 0);
        check_px("x560_black", 0, 560, 0);
        check_px("x639_black", 0, 639, 0);
        check_px("x640_blank", 0, 640, 0);

        sb_push("hsync_pre", 1);
        goto_edge(4 * 655 + 2);
        sb_check(int'(hsync_pin));

        sb_push("hsync_fall0", 2625);
        wait_pin(1'b0, 1'b0, t_fall);
        sb_check(t_fall);
        sb_push("hsync_width", 384);
        wait_pin(1'b0, 1'b1, t_rise);
        sb_check(t_rise - t_fall);

        check_px("x799_blank", 0, 799, 0);
        check_px("line1_x0", LINE, 0, 1);
        sb_push("hsync_period", LINE);
        wait_pin(1'b0, 1'b0, t_next);
        sb_check(t_next - t_fall);

        // Vertical blanking lines still carry hsync.
        check_px("vblank_x0", 2 * LINE, 0, 2);
        check_px("vblank_x300", 2 * LINE, 300, 2);
        sb_push("hsync_in_vblank", 2 * LINE + 2625);
        wait_pin(1'b0, 1'b0, t_fall);
        sb_check(t_fall);

        sb_push("vsync_fall", (VV + VF) * LINE + 1);
        wait_pin(1'b1, 1'b0, v_fall);
        sb_check(v_fall);
        sb_push("hsync_in_vsync", (VV + VF) * LINE + 2625);
        wait_pin(1'b0, 1'b0, t_fall);
        sb_check(t_fall);
        sb_push("vsync_width", VS * LINE);
        wait_pin(1'b1, 1'b1, v_rise);
        sb_check(v_rise - v_fall);
        check_px("last_line_blank", 5 * LINE, 100, 5);

        check_px("frame2_x0", FRAME, 0, 0);
        check_px("frame2_x80", FRAME, 80, 0);
        sb_push("vsync_period", FRAME);
        wait_pin(1'b1, 1'b0, t_next);
        sb_check(t_next - v_fall);

        // Reset mid-frame while hsync is low.
        sb_push("pre_reset_hsync", 0);
        goto_edge(2 * FRAME + LINE + 4 * 700 + 2);
        sb_check(int'(hsync_pin));
        rst_n = 1'b0;
        #2;
        sb_push("async_hsync", 1); sb_check(int'(hsync_pin));
        sb_push("async_vsync", 1); sb_check(int'(vsync_pin));
        sb_push("async_rgb", 0);   sb_check(rgb_now());
        repeat (10) @(posedge clk);
        #1;
        sb_push("held_hsync", 1);  sb_check(int'(hsync_pin));
        rst_n = 1'b1;
        edge_cnt = 0;

        check_px("restart_x0", 0, 0, 0);
        check_px("restart_x80", 0, 80, 0);
        sb_push("restart_hsync", 2625);
        wait_pin(1'b0, 1'b0, t_fall);
        sb_check(t_fall);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
